// File: rtl/rgb_to_yuv_encoder_if.sv
// ---------------------------------------------------------------------------
// rgb_to_yuv_encoder_if
//   Bundles the SRAM bus and the start/done handshake of the milestone encoder.
//   Signals:
//     SRAM_address    [17:0] word address          (master -> SRAM)
//     SRAM_write_data [15:0] write data            (master -> SRAM)
//     SRAM_we_n              write enable, act-low (master -> SRAM)
//     SRAM_read_data  [15:0] read data, 2-cycle latency (SRAM -> master)
//     M_start                start request         (top FSM -> master)
//     M_done                 1-cycle done pulse    (master -> top FSM)
//   Modports: master (encoder side), slave (SRAM / top-level side).
// ---------------------------------------------------------------------------
interface rgb_to_yuv_encoder_if;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic        M_start;
    logic        M_done;

    modport master (
        output SRAM_address, SRAM_write_data, SRAM_we_n, M_done,
        input  SRAM_read_data, M_start
    );

    modport slave (
        input  SRAM_address, SRAM_write_data, SRAM_we_n, M_done,
        output SRAM_read_data, M_start
    );
endinterface

// File: rtl/rgb_to_yuv_encoder.sv
// ---------------------------------------------------------------------------
// rgb_to_yuv_encoder
//   Reads the interleaved 8-bit RGB frame from SRAM and writes it back as
//   planar YUV: Y at full resolution, U/V decimated 2:1 horizontally.
//   Each 4-pixel group takes exactly 12 cycles:
//     RD0..RD5, WAIT0, WAIT1, WY0, WY1, WU, WV
//   Ports:
//     CLOCK_50_I  clock, rising edge
//     Reset       asynchronous reset, active-high
//     bus         rgb_to_yuv_encoder_if.master (SRAM bus + M_start/M_done)
//   Optional feature macro: ENC_CHROMA_AVG_EN
//     defined   -> chroma per pair = (C_even + C_odd + 1) >> 1
//     undefined -> chroma per pair = C_even (odd-pixel U/V not computed)
// ---------------------------------------------------------------------------
module rgb_to_yuv_encoder #(
    parameter int RGB_BASE   = 146944,
    parameter int Y_BASE     = 0,
    parameter int U_BASE     = 38400,
    parameter int V_BASE     = 57600,
    parameter int NUM_GROUPS = 19200
) (
    input  logic                  CLOCK_50_I,
    input  logic                  Reset,
    rgb_to_yuv_encoder_if.master  bus
);
    localparam int GW = $clog2(NUM_GROUPS + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5,
        S_WAIT0, S_WAIT1, S_WY0, S_WY1, S_WU, S_WV
    } state_t;

    state_t           state_q;
    logic [17:0]      addr_q, rgb_q, y_q, u_q, v_q;
    logic [15:0]      wdata_q;
    logic             we_n_q, done_q;
    logic [GW-1:0]    grp_q;
    logic [5:0][15:0] w_q;      // the six RGB words of the current group

    // Unsigned 8-bit inputs, signed 32-bit accumulate, round, offset, clip.
    function automatic logic [7:0] csc(input logic [7:0] r, g, b,
                                       input logic signed [31:0] kr, kg, kb, off);
        logic signed [31:0] acc, res;
        acc = kr * $signed({24'd0, r}) + kg * $signed({24'd0, g})
            + kb * $signed({24'd0, b}) + 32'sd32768;
        res = off + (acc >>> 16);
        if (res < 32'sd0)        return 8'd0;
        else if (res > 32'sd255) return 8'd255;
        else                     return res[7:0];
    endfunction

    // Unpack words {R0,G0},{B0,R1},{G1,B1},{R2,G2},{B2,R3},{G3,B3}.
    logic [3:0][7:0] pr, pg, pb;
    assign pr[0] = w_q[0][15:8];  assign pg[0] = w_q[0][7:0];  assign pb[0] = w_q[1][15:8];
    assign pr[1] = w_q[1][7:0];   assign pg[1] = w_q[2][15:8]; assign pb[1] = w_q[2][7:0];
    assign pr[2] = w_q[3][15:8];  assign pg[2] = w_q[3][7:0];  assign pb[2] = w_q[4][15:8];
    assign pr[3] = w_q[4][7:0];   assign pg[3] = w_q[5][15:8]; assign pb[3] = w_q[5][7:0];

    logic [3:0][7:0] y_d;
    always_comb begin
        y_d = '0;
        for (int p = 0; p < 4; p++)
            y_d[p] = csc(pr[p], pg[p], pb[p], 32'sd16843, 32'sd33030, 32'sd6423, 32'sd16);
    end

    logic [7:0] ua_d, ub_d, va_d, vb_d;
`ifdef ENC_CHROMA_AVG_EN
    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    logic [3:0][7:0] u_pix, v_pix;
    always_comb begin
        u_pix = '0;
        v_pix = '0;
        for (int p = 0; p < 4; p++) begin
            u_pix[p] = csc(pr[p], pg[p], pb[p], -32'sd9699, -32'sd19071, 32'sd28770, 32'sd128);
            v_pix[p] = csc(pr[p], pg[p], pb[p], 32'sd28770, -32'sd24117, -32'sd4653, 32'sd128);
        end
    end
    assign ua_d = avg8(u_pix[0], u_pix[1]);
    assign ub_d = avg8(u_pix[2], u_pix[3]);
    assign va_d = avg8(v_pix[0], v_pix[1]);
    assign vb_d = avg8(v_pix[2], v_pix[3]);
`else
    assign ua_d = csc(pr[0], pg[0], pb[0], -32'sd9699, -32'sd19071, 32'sd28770, 32'sd128);
    assign ub_d = csc(pr[2], pg[2], pb[2], -32'sd9699, -32'sd19071, 32'sd28770, 32'sd128);
    assign va_d = csc(pr[0], pg[0], pb[0], 32'sd28770, -32'sd24117, -32'sd4653, 32'sd128);
    assign vb_d = csc(pr[2], pg[2], pb[2], 32'sd28770, -32'sd24117, -32'sd4653, 32'sd128);
`endif

    // Outputs are registered: the value set on the edge entering a state is
    // what the bus sees during that state.
    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rgb_q   <= '0;
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            done_q  <= 1'b0;
            grp_q   <= '0;
            w_q     <= '0;
        end else begin
            done_q <= 1'b0;
            we_n_q <= 1'b1;

            // Read data lags its address by two cycles.
            case (state_q)
                S_RD2:   w_q[0] <= bus.SRAM_read_data;
                S_RD3:   w_q[1] <= bus.SRAM_read_data;
                S_RD4:   w_q[2] <= bus.SRAM_read_data;
                S_RD5:   w_q[3] <= bus.SRAM_read_data;
                S_WAIT0: w_q[4] <= bus.SRAM_read_data;
                S_WAIT1: w_q[5] <= bus.SRAM_read_data;
                default: ;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (bus.M_start) begin
                        addr_q  <= 18'(RGB_BASE);
                        rgb_q   <= 18'(RGB_BASE + 1);
                        y_q     <= 18'(Y_BASE);
                        u_q     <= 18'(U_BASE);
                        v_q     <= 18'(V_BASE);
                        grp_q   <= '0;
                        state_q <= S_RD0;
                    end
                end
                S_RD0, S_RD1, S_RD2, S_RD3, S_RD4: begin
                    addr_q  <= rgb_q;
                    rgb_q   <= rgb_q + 18'd1;
                    state_q <= state_t'(state_q + 4'd1);
                end
                S_RD5:   state_q <= S_WAIT0;
                S_WAIT0: state_q <= S_WAIT1;
                S_WAIT1: begin
                    // Pixels 0/1 only need words 0..2, already captured.
                    addr_q  <= y_q;
                    wdata_q <= {y_d[0], y_d[1]};
                    we_n_q  <= 1'b0;
                    state_q <= S_WY0;
                end
                S_WY0: begin
                    addr_q  <= y_q + 18'd1;
                    wdata_q <= {y_d[2], y_d[3]};
                    we_n_q  <= 1'b0;
                    y_q     <= y_q + 18'd2;
                    state_q <= S_WY1;
                end
                S_WY1: begin
                    addr_q  <= u_q;
                    wdata_q <= {ua_d, ub_d};
                    we_n_q  <= 1'b0;
                    u_q     <= u_q + 18'd1;
                    state_q <= S_WU;
                end
                S_WU: begin
                    addr_q  <= v_q;
                    wdata_q <= {va_d, vb_d};
                    we_n_q  <= 1'b0;
                    v_q     <= v_q + 18'd1;
                    state_q <= S_WV;
                end
                S_WV: begin
                    if (grp_q == GW'(NUM_GROUPS - 1)) begin
                        grp_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        grp_q   <= grp_q + GW'(1);
                        addr_q  <= rgb_q;
                        rgb_q   <= rgb_q + 18'd1;
                        state_q <= S_RD0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.SRAM_address    = addr_q;
    assign bus.SRAM_write_data = wdata_q;
    assign bus.SRAM_we_n       = we_n_q;
    assign bus.M_done          = done_q;
endmodule
